// File: rtl/tuart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tuart_pkg : shared types for the tuart serial blocks                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package tuart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/tuart_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tuart_sync : 2-flop synchroniser with selectable reset value          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tuart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/tuart_rx_ovs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tuart_rx_ovs : oversampling UART receiver with valid/ready output     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tuart_rx_ovs
  import tuart_pkg::*;
#(
  parameter int      DATA_BITS    = 8,
  parameter int      NR_STOP_BITS = 1,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      OVS          = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 smpl_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o
);

  localparam int            TW          = $clog2(OVS);
  localparam logic [TW-1:0] c_tick_lo   = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] c_tick_mid  = TW'(OVS/2);
  localparam logic [TW-1:0] c_tick_hi   = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] c_tick_last = TW'(OVS - 1);
  localparam logic [3:0]    c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0]    c_last_stop = 4'(NR_STOP_BITS - 1);
  localparam logic          c_odd       = (PARITY == PAR_ODD);
  localparam logic          c_has_par   = (PARITY != PAR_NONE);

  rx_state_e            r_state, w_state_nxt;
  logic                 w_line;
  logic [TW-1:0]        r_tick;
  logic [3:0]           r_bit;
  logic                 r_prev;
  logic [1:0]           r_smp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr, r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_fe, r_pe, r_ovr;
  logic                 w_active, w_vote, w_vote_now, w_wrap, w_done, w_ferr_all;

  tuart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (w_line)
  );

  assign w_active   = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_PARITY) || (r_state == ST_STOP);
  // Majority of the two stored mid-bit samples and the current one.
  assign w_vote     = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_line) | (r_smp[0] & w_line);
  assign w_vote_now = smpl_i && w_active && (r_tick == c_tick_hi);
  assign w_wrap     = smpl_i && w_active && (r_tick == c_tick_last);
  assign w_done     = w_vote_now && (r_state == ST_STOP) && (r_bit == c_last_stop);
  assign w_ferr_all = r_ferr | ~w_vote;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (smpl_i && r_prev && !w_line) w_state_nxt = ST_START;
      ST_START:  if (w_vote_now && w_vote)        w_state_nxt = ST_IDLE;
                 else if (w_wrap)                 w_state_nxt = ST_DATA;
      ST_DATA:   if (w_wrap && (r_bit == c_last_data))
                   w_state_nxt = c_has_par ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_wrap)                      w_state_nxt = ST_STOP;
      ST_STOP:   if (w_done)  w_state_nxt = w_ferr_all ? ST_BREAK : ST_IDLE;
      ST_BREAK:  if (smpl_i && w_line)            w_state_nxt = ST_IDLE;
      default:                                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_prev  <= 1'b1;
      r_smp   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else if (smpl_i) begin
      r_prev <= w_line;
      if (!w_active) begin
        r_tick <= '0;
        r_bit  <= '0;
        r_ferr <= 1'b0;
        r_perr <= 1'b0;
      end else begin
        r_tick <= (r_tick == c_tick_last) ? '0 : r_tick + 1'b1;
        if ((r_tick == c_tick_lo) || (r_tick == c_tick_mid))
          r_smp <= {r_smp[0], w_line};
        if (w_vote_now) begin
          case (r_state)
            ST_DATA:   r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            ST_PARITY: r_perr  <= w_vote ^ (^r_shift) ^ c_odd;
            ST_STOP:   if (!w_vote) r_ferr <= 1'b1;
            default:   ;
          endcase
        end
        // Bit index restarts whenever the wrap also moves to a new phase.
        if (w_wrap)
          r_bit <= (w_state_nxt == r_state) ? r_bit + 4'd1 : 4'd0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done) begin
        if (r_valid && !ready_i) begin
          r_ovr <= 1'b1;
        end else begin
          r_data  <= r_shift;
          r_fe    <= w_ferr_all;
          r_pe    <= c_has_par & r_perr;
          r_valid <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign frame_err_o  = r_fe;
  assign parity_err_o = r_pe;
  assign overrun_o    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_tuart_rx_ovs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tuart_rx_ovs : two receivers (no parity / even parity) checked     |
// | every cycle against a sample-stream decoder model. Rev 1.0            |
// +----------------------------------------------------------------------+
module tb_tuart_rx_ovs;
  import tuart_pkg::*;

  localparam int OVS     = 16;
  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_BREAK = 2;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            smpl  = 1'b0;
  logic [1:0]      rx    = 2'b11;
  logic [1:0]      ready = 2'b11;
  logic [1:0][7:0] dout;
  logic [1:0]      vld, fe, pe, ov;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode [2] = '{1, 1};
  int words    [2] = '{0, 0};
  int ovr_cnt  [2] = '{0, 0};
  logic [7:0] cap_data [2];
  logic       cap_fe   [2];
  logic       cap_pe   [2];

  tuart_rx_ovs #(.DATA_BITS(8), .NR_STOP_BITS(1), .PARITY(PAR_NONE), .OVS(OVS)) u_dut_n (
    .clk_i(clk), .rst_i(rst), .smpl_i(smpl), .rx_i(rx[0]),
    .data_o(dout[0]), .valid_o(vld[0]), .ready_i(ready[0]),
    .frame_err_o(fe[0]), .parity_err_o(pe[0]), .overrun_o(ov[0]));

  tuart_rx_ovs #(.DATA_BITS(8), .NR_STOP_BITS(1), .PARITY(PAR_EVEN), .OVS(OVS)) u_dut_p (
    .clk_i(clk), .rst_i(rst), .smpl_i(smpl), .rx_i(rx[1]),
    .data_o(dout[1]), .valid_o(vld[1]), .ready_i(ready[1]),
    .frame_err_o(fe[1]), .parity_err_o(pe[1]), .overrun_o(ov[1]));

  always #5 clk = ~clk;

  // Oversampling strobe with random spacing (0..2 idle cycles between ticks)
  initial begin
    int gap;
    gap = 0;
    forever begin
      @(posedge clk); #1;
      if (gap == 0) begin smpl = 1'b1; gap = $urandom_range(0, 2); end
      else begin smpl = 1'b0; gap--; end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++)
        ready[u] = (rdy_mode[u] == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode[u] == 1);
    end
  end

  // ---------------- behavioural model ----------------
  bit         sy1 [2], sy2 [2], mprev [2];
  int         mode [2], pos [2];
  bit         hist [2][256];
  bit         m_valid [2], m_fe [2], m_pe [2], m_ov [2];
  bit [7:0]   m_data [2];

  function automatic int nbits(input int u);
    return (u == 1) ? 11 : 10;
  endfunction

  // Majority of the three mid-bit samples of the bit starting at sample 'base'.
  function automatic bit vote3(input int u, input int base);
    int ones;
    ones = int'(hist[u][base + OVS/2 - 1]) + int'(hist[u][base + OVS/2]) +
           int'(hist[u][base + OVS/2 + 1]);
    return ones >= 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        sy1[u] = 1'b1; sy2[u] = 1'b1; mprev[u] = 1'b1;
        mode[u] = M_IDLE; pos[u] = 0;
        m_valid[u] = 1'b0; m_data[u] = 8'h00; m_fe[u] = 1'b0; m_pe[u] = 1'b0; m_ov[u] = 1'b0;
      end else begin
        bit line, done, hold, f_fe, f_pe;
        bit [7:0] f_d;
        line = sy2[u]; sy2[u] = sy1[u]; sy1[u] = rx[u];
        done = 1'b0; f_d = 8'h00; f_fe = 1'b0; f_pe = 1'b0;
        hold = m_valid[u] && !ready[u];
        if (smpl) begin
          if (mode[u] == M_IDLE) begin
            if (mprev[u] && !line) begin mode[u] = M_FRAME; pos[u] = 0; end
          end else if (mode[u] == M_BREAK) begin
            if (line) mode[u] = M_IDLE;
          end else begin
            hist[u][pos[u]] = line;
            if (pos[u] == OVS/2 + 1 && vote3(u, 0)) begin
              mode[u] = M_IDLE;
            end else if (pos[u] == (nbits(u) - 1) * OVS + OVS/2 + 1) begin
              for (int b = 0; b < 8; b++) f_d[b] = vote3(u, (b + 1) * OVS);
              if (u == 1) f_pe = vote3(u, 9 * OVS) ^ (^f_d);
              f_fe = !vote3(u, (nbits(u) - 1) * OVS);
              done = 1'b1;
              mode[u] = f_fe ? M_BREAK : M_IDLE;
            end
            pos[u]++;
          end
          mprev[u] = line;
        end
        m_ov[u] = 1'b0;
        if (done && hold) m_ov[u] = 1'b1;
        else if (done) begin
          m_valid[u] = 1'b1; m_data[u] = f_d; m_fe[u] = f_fe; m_pe[u] = f_pe;
        end else if (m_valid[u] && ready[u]) m_valid[u] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (vld[u] !== m_valid[u] || ov[u] !== m_ov[u]) begin
        n_fail++;
        $display("FAIL hs_u%0d t=%0t: valid=%b overrun=%b, model valid=%b overrun=%b",
                 u, $time, vld[u], ov[u], m_valid[u], m_ov[u]);
      end
      if (m_valid[u]) begin
        n_checks++;
        if (dout[u] !== m_data[u] || fe[u] !== m_fe[u] || pe[u] !== m_pe[u]) begin
          n_fail++;
          $display("FAIL word_u%0d t=%0t: data=%h fe=%b pe=%b, model data=%h fe=%b pe=%b",
                   u, $time, dout[u], fe[u], pe[u], m_data[u], m_fe[u], m_pe[u]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (vld[u] === 1'b1) begin
        cap_data[u] = dout[u]; cap_fe[u] = fe[u]; cap_pe[u] = pe[u];
        if (ready[u]) words[u]++;
      end
      if (ov[u] === 1'b1) ovr_cnt[u]++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (smpl !== 1'b1);
    #1;
  endtask

  task automatic send_bit(input int u, input logic v);
    rx[u] = v;
    repeat (OVS) wait_tick();
  endtask

  task automatic idle(input int u, input int nb);
    repeat (nb) send_bit(u, 1'b1);
  endtask

  task automatic send_frame(input int u, input logic [7:0] d, input bit bad_par, input bit bad_stop);
    send_bit(u, 1'b0);
    for (int b = 0; b < 8; b++) send_bit(u, d[b]);
    if (u == 1) send_bit(u, (^d) ^ bad_par);
    send_bit(u, !bad_stop);
  endtask

  initial begin
    int w, o;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(vld[0]), 0);
    chk("rst_data",  int'(dout[0]), 0);
    chk("rst_flags", int'({fe[0], pe[0], ov[0]}), 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(0, 2);

    w = words[0];
    send_frame(0, 8'hA5, 1'b0, 1'b0); idle(0, 1);
    chk("a5_count", words[0] - w, 1);
    chk("a5_data",  int'(cap_data[0]), 'hA5);
    chk("a5_flags", int'({cap_fe[0], cap_pe[0]}), 0);

    idle(1, 1);
    w = words[1];
    send_frame(1, 8'h03, 1'b1, 1'b0); idle(1, 1);
    chk("par_bad_count", words[1] - w, 1);
    chk("par_bad_data",  int'(cap_data[1]), 'h03);
    chk("par_bad_pe",    int'(cap_pe[1]), 1);
    send_frame(1, 8'h03, 1'b0, 1'b0); idle(1, 1);
    chk("par_ok_pe",     int'(cap_pe[1]), 0);
    chk("par_ok_count",  words[1] - w, 2);

    w = words[0];
    send_frame(0, 8'h55, 1'b0, 1'b1);
    chk("ferr_count", words[0] - w, 1);
    chk("ferr_flag",  int'(cap_fe[0]), 1);
    chk("ferr_data",  int'(cap_data[0]), 'h55);
    w = words[0];
    repeat (20) send_bit(0, 1'b0);
    chk("break_quiet", words[0] - w, 0);
    idle(0, 2);
    send_frame(0, 8'h3C, 1'b0, 1'b0); idle(0, 1);
    chk("after_break", words[0] - w, 1);
    chk("after_break_data", int'(cap_data[0]), 'h3C);

    w = words[0];
    rx[0] = 1'b0; repeat (4) wait_tick(); rx[0] = 1'b1;
    idle(0, 2);
    chk("glitch_quiet", words[0] - w, 0);
    send_frame(0, 8'h96, 1'b0, 1'b0); idle(0, 1);
    chk("glitch_recover", int'(cap_data[0]), 'h96);

    rdy_mode[0] = 0; idle(0, 1);
    w = words[0]; o = ovr_cnt[0];
    send_frame(0, 8'h11, 1'b0, 1'b0); idle(0, 1);
    send_frame(0, 8'h22, 1'b0, 1'b0); idle(0, 1);
    @(negedge clk);
    chk("ovr_pulses", ovr_cnt[0] - o, 1);
    chk("ovr_held",   int'(dout[0]), 'h11);
    chk("ovr_valid",  int'(vld[0]), 1);
    chk("ovr_noacc",  words[0] - w, 0);
    rdy_mode[0] = 1;
    repeat (4) @(negedge clk);
    chk("ovr_accept", words[0] - w, 1);
    chk("ovr_drain",  int'(vld[0]), 0);

    send_bit(0, 1'b0);
    send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
    @(posedge clk); #1; rst = 1'b1; rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_data",  int'(dout[0]), 0);
    chk("midrst_valid", int'(vld[0]), 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(0, 2);
    w = words[0];
    send_frame(0, 8'h7E, 1'b0, 1'b0); idle(0, 2);
    chk("midrst_count", words[0] - w, 1);
    chk("midrst_word",  int'(cap_data[0]), 'h7E);

    rdy_mode[0] = 2; rdy_mode[1] = 2;
    for (int i = 0; i < 12; i++) begin
      for (int u = 0; u < 2; u++) begin
        logic [7:0] d;
        d = 8'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          rx[u] = 1'b0; repeat ($urandom_range(1, 5)) wait_tick(); rx[u] = 1'b1;
          idle(u, 1);
        end
        send_frame(u, d, (u == 1) && ($urandom_range(0, 3) == 0), $urandom_range(0, 5) == 0);
        idle(u, $urandom_range(0, 2));
      end
    end
    rdy_mode[0] = 1; rdy_mode[1] = 1;
    idle(0, 2); idle(1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tuart_rx_ovs.md
TUART_RX_OVS -- requirements
Module: tuart_rx_ovs

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter NR_STOP_BITS, default 1, stop bits per frame; legal values 1 and 2.
REQ-003 The block SHALL have parameter PARITY, default PAR_NONE, parity mode from tuart_pkg: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 The block SHALL have parameter OVS, default 16, smpl_i ticks per bit; even, at least 8.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit, reset; asynchronous, active-high.
REQ-007 The block SHALL have port smpl_i, input, 1 bit, one-cycle oversampling strobe at OVS x baud.
REQ-008 The block SHALL have port rx_i, input, 1 bit, asynchronous serial line; idle level high.
REQ-009 The block SHALL have port data_o, output, DATA_BITS bits, received word; LSB is the first bit received.
REQ-010 The block SHALL have port valid_o, output, 1 bit, data_o and error flags valid; held high until accepted.
REQ-011 The block SHALL have port ready_i, input, 1 bit, consumer accepts the word in any cycle where valid_o and ready_i are both high.
REQ-012 The block SHALL have port frame_err_o, output, 1 bit, stop-bit error on the current word; qualified by valid_o.
REQ-013 The block SHALL have port parity_err_o, output, 1 bit, parity mismatch on the current word; qualified by valid_o; always 0 when PARITY = PAR_NONE.
REQ-014 The block SHALL have port overrun_o, output, 1 bit, one-cycle pulse when a completed frame is dropped.

Function
REQ-015 rx_i SHALL pass through a 2-FF synchroniser before any use; all timing below is relative to the synchronised line.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-017 The tick counter (0..OVS-1) and the bit counter SHALL advance only in cycles where smpl_i = 1.
REQ-018 IDLE: a high-to-low transition of the synchronised line SHALL move the FSM to START and clear the tick counter.
REQ-019 Each bit value SHALL be the majority vote of the three samples taken at ticks OVS/2-1, OVS/2 and OVS/2+1.
REQ-020 START: if the voted start bit is 1, the event is a false start and the FSM SHALL return to IDLE with no output.
REQ-021 START: if the voted start bit is 0, the FSM SHALL enter DATA when the tick counter wraps.
REQ-022 DATA: the block SHALL shift in DATA_BITS voted bits LSB first, then go to PARITY (if PARITY != PAR_NONE) or to STOP.
REQ-023 PARITY: the expected bit SHALL be the XOR of the data bits for PAR_EVEN and its inverse for PAR_ODD; a mismatch sets the parity error.
REQ-024 STOP: every stop bit SHALL be sampled; any voted 0 sets the frame error.
REQ-025 The frame SHALL complete at the tick OVS/2+1 of the last stop bit, without waiting for the bit end, to allow for baud skew.
REQ-026 valid_o, data_o and both error flags SHALL update on the clk_i edge after the completing smpl_i cycle.
REQ-027 A completed frame with a stop-bit error SHALL still be delivered, with frame_err_o = 1.
REQ-028 After a frame error the FSM SHALL go to BREAK and stay there until the line is sampled high, then go to IDLE.
REQ-029 A frame that completes while valid_o = 1 and ready_i = 0 SHALL be discarded; the held word is kept and overrun_o pulses for exactly one cycle.
REQ-030 If the frame completes in the same cycle that the held word is accepted, the new word SHALL load and valid_o SHALL stay high, with no overrun.
REQ-031 After completion the FSM SHALL return to IDLE; a start edge SHALL be recognised from the next smpl_i cycle, so back-to-back frames are received.

Reset
REQ-032 When rst_i is high, the FSM SHALL be in IDLE, both counters SHALL be 0, and both synchroniser flops SHALL be 1.
REQ-033 When rst_i is high, data_o SHALL be 0 and valid_o, frame_err_o, parity_err_o and overrun_o SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL restart only on a new falling edge.

Structure
REQ-035 tuart_pkg SHALL hold the parity enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state enum.
REQ-036 The synchroniser SHALL be the sub-module tuart_sync, a 2-flop synchroniser with a reset value parameter, reusable by the TX path.
REQ-037 The design SHALL contain no other sub-modules; the majority vote is local logic.

Verification
REQ-038 The bench SHALL drive DATA_BITS = 8, PAR_NONE, 1 stop bit, OVS = 16, and send frame 0xA5, expecting data_o = 0xA5, valid_o high and no error flags.
REQ-039 The bench SHALL set PAR_EVEN and send 0x03 with parity bit 1, expecting parity_err_o = 1 with data_o = 0x03; sending it again with parity bit 0 SHALL give no error.
REQ-040 The bench SHALL send 0x55 with a stop bit of 0, expecting frame_err_o = 1; then hold the line low for 20 bit times and expect no further valid_o until after the line returns high.
REQ-041 The bench SHALL apply a 4-tick low glitch on an idle line, expecting no valid_o and the FSM back in IDLE.
REQ-042 The bench SHALL hold ready_i = 0 and send 0x11 then 0x22, expecting data_o to stay 0x11 and one overrun_o pulse; then raise ready_i and expect the handshake to complete.
REQ-043 The bench SHALL assert rst_i in the middle of the DATA state, then send 0x7E after release, expecting exactly one word, 0x7E.
